// File: rtl/trivium_stream_ctrl.sv
// trivium_stream_ctrl
//
// Sequencer for an external bit-serial Trivium keystream core. A job starts
// with a one-cycle key/IV load, runs WARMUP discarded core steps, then steps
// the core one bit per cycle and packs the bits (first bit -> bit 0) into a
// W-bit keystream buffer. A full buffer is transferred into the registered
// output word (optionally XORed with a plaintext word) via valid/ready.
// While the buffer is full the core is stalled, so no keystream is lost.
//
// Configuration macro: TRIV_XOR_EN
//   defined   : out_data = keystream ^ in_data, plaintext handshake active.
//   undefined : keystream-only export; in_ready tied 0, in_data ignored.
//
// Ports:
//   clk, reset (synchronous, active-low)
//   start, len[15:0]       job request (len in W-bit words, captured once)
//   busy, done             status; done is a one-cycle pulse
//   core_load, core_en     core control (act at the next rising edge)
//   core_z                 current keystream bit from the core
//   in_data/in_valid/in_ready     plaintext word stream
//   out_data/out_valid/out_ready  ciphertext (or keystream) word stream

module trivium_stream_ctrl #(
    parameter int WARMUP = 1152,
    parameter int W      = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  len,
    output logic         busy,
    output logic         done,
    output logic         core_load,
    output logic         core_en,
    input  logic         core_z,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int WCW = $clog2(WARMUP + 1);
    localparam int BCW = $clog2(W + 1);
    localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP - 1);
    localparam logic [BCW-1:0] BIT_FULL  = BCW'(W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WARM,
        ST_COLLECT,
        ST_DRAIN
    } state_t;

    state_t         state_reg, state_next;
    logic [WCW-1:0] warm_cnt_reg;
    logic [15:0]    word_cnt_reg;
    logic [BCW-1:0] bit_cnt_reg;
    logic [W-1:0]   ks_buf_reg, ks_buf_next;
    logic [W-1:0]   out_data_reg;
    logic           out_valid_reg;
    logic           done_reg;

    logic           buf_full;
    logic           out_free;
    logic           xfer_rdy;
    logic           xfer;
    logic           shift_en;
    logic [W-1:0]   word_value;

    assign buf_full = (bit_cnt_reg == BIT_FULL);
    // Output register can take a new word if empty or being emptied this cycle.
    assign out_free = !out_valid_reg || out_ready;
    assign xfer_rdy = (state_reg == ST_COLLECT) && buf_full && out_free;
    assign shift_en = (state_reg == ST_COLLECT) && !buf_full;

`ifdef TRIV_XOR_EN
    assign in_ready   = xfer_rdy;
    assign xfer       = xfer_rdy && in_valid;
    assign word_value = ks_buf_reg ^ in_data;
`else
    logic unused_plaintext;
    assign unused_plaintext = ^{in_data, in_valid};
    assign in_ready   = 1'b0;
    assign xfer       = xfer_rdy;
    assign word_value = ks_buf_reg;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and core control
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        core_load  = 1'b0;
        core_en    = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start && (len != 16'd0)) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                core_load  = 1'b1;
                state_next = ST_WARM;
            end
            ST_WARM: begin
                core_en = 1'b1;
                if (warm_cnt_reg == WARM_LAST) begin
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // The core only advances while there is room for its bit.
                core_en = !buf_full;
                if (xfer && (word_cnt_reg == 16'd1)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave only once the last word has gone; done pulses in the
                // final DRAIN cycle so a start coinciding with done is ignored.
                if (!out_valid_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy      = (state_reg != ST_IDLE);
    assign done      = done_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;

    // ------------------------------------------------------------------
    // Keystream buffer: bit gi captures core_z when the bit counter points
    // at it; cleared on load and on every transfer.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_ks_bit
            assign ks_buf_next[gi] =
                (xfer || (state_reg == ST_LOAD)) ? 1'b0 :
                (shift_en && (bit_cnt_reg == BCW'(gi))) ? core_z :
                ks_buf_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            warm_cnt_reg  <= '0;
            word_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            ks_buf_reg    <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg   <= 1'b0;
            ks_buf_reg <= ks_buf_next;

            if ((state_reg == ST_IDLE) && start) begin
                if (len == 16'd0) begin
                    done_reg <= 1'b1;
                end else begin
                    word_cnt_reg <= len;
                end
            end

            if (state_reg == ST_WARM) begin
                warm_cnt_reg <= warm_cnt_reg + 1'b1;
            end else begin
                warm_cnt_reg <= '0;
            end

            if (state_reg == ST_LOAD) begin
                bit_cnt_reg <= '0;
            end else if (xfer) begin
                bit_cnt_reg <= '0;
            end else if (shift_en) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end

            if (xfer) begin
                out_data_reg  <= word_value;
                out_valid_reg <= 1'b1;
                if (word_cnt_reg != 16'd0) begin
                    word_cnt_reg <= word_cnt_reg - 16'd1;
                end
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
                if (state_reg == ST_DRAIN) begin
                    done_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_trivium_stream_ctrl.sv
module tb_trivium_stream_ctrl;

    localparam int W      = 8;
    localparam int WARMUP = 1152;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  len = 16'd0;
    logic         busy, done, core_load, core_en, core_z;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;

    trivium_stream_ctrl #(.WARMUP(WARMUP), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .core_load (core_load),
        .core_en   (core_en),
        .core_z    (core_z),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // ---------------- core model ----------------
    // steps = number of core rounds since the last load.
    int steps = 0;
    int z_mode = 0;   // 0: constant 1, 1: post-warm-up step parity, 2: word patterns

    always @(posedge clk) begin
        if (core_load) steps <= 0;
        else if (core_en) steps <= steps + 1;
    end

    function automatic logic [7:0] pat_word(input int k);
        case (k % 3)
            0:       return 8'h3C;
            1:       return 8'hC5;
            default: return 8'h69;
        endcase
    endfunction

    function automatic logic model_z(input int s, input int m);
        logic [7:0] p;
        int r;
        if (m == 0) return 1'b1;
        if (s < WARMUP) return 1'b1;   // warm-up bits are 1 so any leak shows
        r = s - WARMUP;
        if (m == 1) return r[0];
        p = pat_word(r / 8);
        return p[r % 8];
    endfunction

    assign core_z = model_z(steps, z_mode);

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    int load_rel, load_cnt, en_cnt, en_first_rel, en_1152_rel, en_1153_rel;
    int ir_first_rel, ir_cnt, ov_first_rel, done_cnt, done_rel, busy_cnt;
    int busy_after_done, late_stall_en, unstable;
    logic [7:0] held;
    logic [7:0] words[$];

    // Runs one job and records what the DUT did; the calling test judges it.
    task automatic run_job(input logic [15:0] l, input logic [7:0] d, input logic iv,
                           input int st_from, input int st_len, input bit rs, input int budget);
        load_rel = 0; load_cnt = 0; en_cnt = 0; en_first_rel = 0; en_1152_rel = 0;
        en_1153_rel = 0; ir_first_rel = 0; ir_cnt = 0; ov_first_rel = 0; done_cnt = 0;
        done_rel = 0; busy_cnt = 0; busy_after_done = 0; late_stall_en = 0; unstable = 0;
        held = '0;
        words.delete();
        @(negedge clk);
        start = 1'b1; len = l; in_data = d; in_valid = iv; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int rel = 1; rel <= budget; rel++) begin
            out_ready = !((rel >= st_from) && (rel < st_from + st_len));
            start = 1'b0;
            #1;
            if (busy) busy_cnt++;
            if (core_load) begin
                load_cnt++;
                if (load_rel == 0) load_rel = rel;
            end
            if (core_en) begin
                en_cnt++;
                if (en_cnt == 1) en_first_rel = rel;
                if (en_cnt == WARMUP) en_1152_rel = rel;
                if (en_cnt == WARMUP + 1) en_1153_rel = rel;
            end
            if (in_ready) begin
                ir_cnt++;
                if (ir_first_rel == 0) ir_first_rel = rel;
            end
            if (out_valid && ov_first_rel == 0) ov_first_rel = rel;
            if (rel == st_from) held = out_data;
            if ((rel >= st_from) && (rel < st_from + st_len)) begin
                if (out_valid && out_data !== held) unstable++;
                if ((rel >= st_from + 10) && core_en) late_stall_en++;
            end
            if (out_valid && out_ready) begin
                words.push_back(out_data);
                $display("cycle %0d: word %0d out_data=%h", rel, words.size() - 1, out_data);
            end
            if (done_rel != 0 && rel > done_rel && (busy || core_load)) busy_after_done++;
            if (done) begin
                done_cnt++;
                if (done_rel == 0) begin
                    done_rel = rel;
                    if (rs) start = 1'b1;   // collides with done: must be ignored
                end
            end
            if (done_rel != 0 && rel >= done_rel + 4) break;
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (done_rel == 0) begin
            errors++;
            $display("FAIL job_timeout: done not seen within %0d cycles", budget);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, core_load, core_en, in_ready, out_valid, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0",
                     {busy, done, core_load, core_en, in_ready, out_valid, out_data});
        end
        $display("reset applied, outputs observed idle");
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] exp_w;
`ifdef TRIV_XOR_EN
        exp_w = 8'hA5;
`else
        exp_w = 8'hFF;
`endif
        z_mode = 0;
        run_job(16'd2, 8'h5A, 1'b1, 0, 0, 1'b0, 3000);
        checks++; if (load_rel !== 1 || load_cnt !== 1) begin errors++;
            $display("FAIL basic_load: rel %0d cnt %0d required 1/1", load_rel, load_cnt); end
        checks++; if (en_first_rel !== 2) begin errors++;
            $display("FAIL basic_en_first: got %0d required 2", en_first_rel); end
        checks++; if (en_1152_rel !== 1153) begin errors++;
            $display("FAIL basic_warm_end: got %0d required 1153", en_1152_rel); end
        checks++; if (en_1153_rel !== 1154) begin errors++;
            $display("FAIL basic_first_kept: got %0d required 1154", en_1153_rel); end
        checks++; if (ov_first_rel !== 1163) begin errors++;
            $display("FAIL basic_first_valid: got %0d required 1163", ov_first_rel); end
`ifdef TRIV_XOR_EN
        checks++; if (ir_first_rel !== 1162) begin errors++;
            $display("FAIL basic_in_ready: got %0d required 1162", ir_first_rel); end
`else
        checks++; if (ir_cnt !== 0) begin errors++;
            $display("FAIL basic_in_ready: got %0d cycles required 0", ir_cnt); end
`endif
        checks++; if (words.size() !== 2) begin errors++;
            $display("FAIL basic_word_count: got %0d required 2", words.size()); end
        for (int i = 0; i < words.size(); i++) begin
            checks++; if (words[i] !== exp_w) begin errors++;
                $display("FAIL basic_word%0d: got %h required %h", i, words[i], exp_w); end
        end
        checks++; if (done_cnt !== 1) begin errors++;
            $display("FAIL basic_done: got %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_bit_order();
        z_mode = 1;
        run_job(16'd1, 8'h00, 1'b1, 0, 0, 1'b0, 3000);
        checks++; if (words.size() !== 1) begin errors++;
            $display("FAIL order_count: got %0d required 1", words.size()); end
        else begin
            checks++; if (words[0] !== 8'hAA) begin errors++;
                $display("FAIL order_word: got %h required aa", words[0]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_w;
        z_mode = 2;
        run_job(16'd3, 8'h0F, 1'b1, 1163, 50, 1'b0, 3000);
        checks++; if (unstable !== 0) begin errors++;
            $display("FAIL stall_stable: %0d changed cycles required 0", unstable); end
        checks++; if (late_stall_en !== 0) begin errors++;
            $display("FAIL stall_core_en: %0d enable cycles required 0", late_stall_en); end
        checks++; if (words.size() !== 3) begin errors++;
            $display("FAIL stall_count: got %0d required 3", words.size()); end
        for (int i = 0; i < words.size(); i++) begin
`ifdef TRIV_XOR_EN
            exp_w = pat_word(i) ^ 8'h0F;
`else
            exp_w = pat_word(i);
`endif
            checks++; if (words[i] !== exp_w) begin errors++;
                $display("FAIL stall_word%0d: got %h required %h", i, words[i], exp_w); end
        end
        checks++; if (done_cnt !== 1) begin errors++;
            $display("FAIL stall_done: got %0d pulses required 1", done_cnt); end
    endtask

    task automatic test_len_zero();
        z_mode = 0;
        run_job(16'd0, 8'h00, 1'b1, 0, 0, 1'b0, 20);
        checks++; if (done_rel !== 1 || done_cnt !== 1) begin errors++;
            $display("FAIL zero_done: rel %0d cnt %0d required 1/1", done_rel, done_cnt); end
        checks++; if (busy_cnt !== 0 || load_cnt !== 0 || en_cnt !== 0) begin errors++;
            $display("FAIL zero_activity: busy %0d load %0d en %0d required 0", busy_cnt, load_cnt, en_cnt); end
    endtask

    task automatic test_back_to_back();
        z_mode = 0;
        run_job(16'd1, 8'h00, 1'b1, 0, 0, 1'b1, 3000);
        checks++; if (busy_after_done !== 0) begin errors++;
            $display("FAIL done_start: %0d busy/load cycles after done required 0", busy_after_done); end
        checks++; if (done_cnt !== 1) begin errors++;
            $display("FAIL done_start_pulses: got %0d required 1", done_cnt); end
    endtask

    task automatic test_reset_midjob();
        int en_at_600;
        en_at_600 = 0;
        z_mode = 0;
        @(negedge clk);
        start = 1'b1; len = 16'd2; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int rel = 1; rel < 600; rel++) @(negedge clk);
        #1;
        en_at_600 = core_en;
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (en_at_600 !== 1) begin errors++;
            $display("FAIL midjob_warm: core_en %0d at cycle 600 required 1", en_at_600); end
        checks++;
        if ({busy, done, core_load, core_en, in_ready, out_valid, out_data} !== '0) begin
            errors++;
            $display("FAIL midjob_reset_outputs: got %b required 0",
                     {busy, done, core_load, core_en, in_ready, out_valid, out_data});
        end
        $display("reset applied at cycle 600 of a job");
        reset = 1'b1;
        run_job(16'd1, 8'h00, 1'b1, 0, 0, 1'b0, 3000);
        checks++; if (load_rel !== 1) begin errors++;
            $display("FAIL restart_load: got %0d required 1", load_rel); end
        checks++; if (en_first_rel !== 2 || en_1153_rel !== 1154) begin errors++;
            $display("FAIL restart_warm: first %0d kept %0d required 2/1154", en_first_rel, en_1153_rel); end
        checks++; if (ov_first_rel !== 1163) begin errors++;
            $display("FAIL restart_valid: got %0d required 1163", ov_first_rel); end
    endtask

    task automatic test_keystream_only();
        z_mode = 0;
`ifndef TRIV_XOR_EN
        run_job(16'd1, 8'h5A, 1'b0, 0, 0, 1'b0, 3000);
        checks++; if (ir_cnt !== 0) begin errors++;
            $display("FAIL ks_in_ready: got %0d cycles required 0", ir_cnt); end
        checks++; if (words.size() !== 1) begin errors++;
            $display("FAIL ks_count: got %0d required 1", words.size()); end
        else begin
            checks++; if (words[0] !== 8'hFF) begin errors++;
                $display("FAIL ks_word: got %h required ff", words[0]); end
        end
`else
        // With the XOR path enabled, no plaintext means no output word.
        int seen_valid;
        int got_done;
        logic [7:0] w;
        seen_valid = 0; got_done = 0; w = '0;
        @(negedge clk);
        start = 1'b1; len = 16'd1; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int rel = 1; rel <= 1300; rel++) begin
            #1;
            if (out_valid) seen_valid++;
            @(negedge clk);
        end
        checks++; if (seen_valid !== 0) begin errors++;
            $display("FAIL ks_no_plaintext: out_valid %0d cycles required 0", seen_valid); end
        in_valid = 1'b1;
        for (int rel = 0; rel < 50 && got_done == 0; rel++) begin
            #1;
            if (out_valid && out_ready) begin
                w = out_data;
                $display("cycle +%0d: word out_data=%h", rel, out_data);
            end
            if (done) got_done = 1;
            @(negedge clk);
        end
        checks++; if (got_done !== 1 || w !== 8'hFF) begin errors++;
            $display("FAIL ks_late_plaintext: done %0d word %h required 1/ff", got_done, w); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bit_order();
        test_backpressure();
        test_len_zero();
        test_back_to_back();
        test_reset_midjob();
        test_keystream_only();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trivium_stream_ctrl.md
# trivium_stream_ctrl

Sequencer for the Trivium keystream core. On a `start` request it loads key/IV into the core, runs the fixed warm-up rounds with output discarded, then steps the core one bit per cycle and packs the bits into W-bit words. Each word is XORed with a plaintext word and emitted through valid/ready handshakes. The block sits between the bus-side data FIFOs and the bit-serial core; the core itself is external and driven through `core_*` ports.

## Interface
- `WARMUP`, default 1152 — number of discarded core steps after load (4 × 288).
- `W`, default 8 — output word width in bits.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-low.
- `start` in 1 — begin a job; sampled only in IDLE.
- `len` in 16 — number of W-bit words in the job; captured on accepted `start`.
- `busy` out 1 — high in every state except IDLE.
- `done` out 1 — one-cycle pulse after the last word is accepted downstream.
- `core_load` out 1 — core loads key/IV at the next edge.
- `core_en` out 1 — core advances one round at the next edge.
- `core_z` in 1 — keystream bit of the core's current state; combinational from the core.
- `in_data` in W — plaintext word.
- `in_valid` in 1 — plaintext handshake.
- `in_ready` out 1 — plaintext handshake.
- `out_data` out W — ciphertext word, registered.
- `out_valid` out 1 — output handshake.
- `out_ready` in 1 — output handshake.

## Operation
- States: IDLE, LOAD, WARM, COLLECT, DRAIN.
- IDLE, when `start`=1:
  - `len`≠0: capture `len`, go to LOAD.
  - `len`=0: pulse `done` next cycle, stay IDLE, no core activity.
- LOAD: exactly one cycle with `core_load`=1, then go to WARM.
- WARM: `core_en`=1 for exactly `WARMUP` cycles, `core_z` ignored, then go to COLLECT.
- COLLECT: while the keystream buffer is not full, `core_en`=1 and `core_z` is shifted in.
  - The first bit lands in buffer bit 0; bit i lands in bit i.
  - After W bits the buffer is full and `core_en`=0; the core stalls and the keystream is not lost.
- Transfer, with the buffer full:
  - Occurs when the plaintext is valid and the output register is empty or draining (`!out_valid || out_ready`).
  - `in_ready` is high only under exactly that condition.
  - On the transfer: `out_data` ← buffer ^ `in_data`, `out_valid`=1, buffer cleared, words-remaining decremented.
  - No `core_en` in the transfer cycle.
- When words-remaining reaches 0 on a transfer, go to DRAIN.
- DRAIN: wait for `out_valid && out_ready`, pulse `done`, go to IDLE.
- `start` while busy is ignored. `len` is sampled once per job.
- Counters:
  - Warm counter is `$clog2(WARMUP+1)` bits.
  - Word counter is 16 bits, no wrap: it stops at 0.
  - Bit counter is `$clog2(W+1)` bits.
- Reset (`reset`=0 at an edge), including mid-job:
  - Go to IDLE; all outputs 0 (`busy`, `done`, `core_load`, `core_en`, `in_ready`, `out_valid`, `out_data`).
  - Buffer and counters are cleared; a partial word is discarded. The core must be reloaded by the next job.

## Timing
- `start` accepted at edge 0:
  - `core_load`=1 in cycle 1.
  - `core_en`=1 in cycles 2..1153.
  - The first kept bit is sampled in cycle 1154.
- For W=8, the buffer is full after cycle 1161; the earliest transfer (`in_ready`=1) is cycle 1162, and `out_valid` rises in cycle 1163.
- Steady state with no backpressure: one word per W+1 cycles.
- `out_data` and `out_valid` hold stable while `out_valid && !out_ready`.
- Simultaneous events:
  - A transfer and a downstream accept in the same cycle are legal: the old word leaves and the new word is loaded.
  - `done` and a new `start` in the same cycle: `start` is ignored (the block is not yet in IDLE when sampled).

## Configuration
- `TRIV_XOR_EN` defined: behaviour as above; ciphertext = keystream ^ plaintext.
- `TRIV_XOR_EN` undefined:
  - `in_ready` is tied 0 and `in_data` is unused.
  - The transfer condition drops `in_valid`; `out_data` = raw keystream word.
  - Keystream-only mode for key-stream export and core bring-up.

## Test plan
- `core_z` held at 1, `len`=2, `in_data`=0x5A, `in_valid`=1, `out_ready`=1 -> two `out_data`=0xA5 words, `done` pulse once, exactly 1152 `core_en` cycles before the first kept bit, first `out_valid` at cycle 1163.
- Bench `core_z` = step-count parity (1 on odd steps, steps counted from the first post-warm-up step), `len`=1, `in_data`=0x00 -> `out_data`=0xAA. This checks bit order and that no warm-up bit leaks.
- `out_ready`=0 for 50 cycles with `len`=3 -> second word stalls in the buffer, `core_en`=0 during the stall, `out_data` stable; after release the words arrive in order with correct values.
- `start` with `len`=0 -> `done` pulse in cycle 1; `busy`, `core_load`, `core_en` never assert.
- `reset` low in cycle 600 (mid-WARM), then restart -> all outputs 0 the cycle after the reset edge; new job shows `core_load` again and a full 1152-cycle warm-up.
- `TRIV_XOR_EN` undefined, `core_z`=1, `in_valid`=0 -> `out_data`=0xFF, `in_ready` never asserts.
